// File: rtl/fia_pkg.sv
// Shared fuzzification-stage definitions: Q12 constants, divider operand
// widths, the arbiter sequencer state type and the quotient-to-degree mapping.
package fia_pkg;

    localparam logic [31:0] Q_ONE     = 32'h0000_1000;
    localparam int          Q_SHIFT   = 12;
    localparam int          DVD_W_DEF = 64;
    localparam int          DVS_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_DRAIN  = 2'b10
    } arb_state_e;

    // Degree is the quotient's sign bit followed by its low 31 magnitude bits.
    function automatic logic [31:0] q12_degree(input logic [63:0] q);
        return {q[63], q[30:0]};
    endfunction

endpackage

// File: rtl/div_arb_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each divide in flight.
// Push is ignored when full and pop is ignored when empty; count_nxt exposes
// the occupancy after the current cycle so callers can act on it same-cycle.
module div_arb_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_s, empty_s;
    logic          do_push_s, do_pop_s;

    assign full_s    = (count_q == (AW+1)'(DEPTH));
    assign empty_s   = (count_q == '0);
    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_q;
    assign count_nxt = count_d;
    assign pop_data  = mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_comb begin
        do_push_s = push & ~full_s;
        do_pop_s  = pop & ~empty_s;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents are don't-care until written so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: shares one pipelined Q12 divider between NUM_REQ
// degree calculators. Round-robin one-hot grant, registered operand strobe,
// in-order tag FIFO steering quotients back as one-hot responses, and a
// flush/drain sequencer.
// Build option: DIV_ZERO_GUARD_EN replaces a zero divisor with Q_ONE and a
// zero dividend (result 0) and raises sticky err_div_zero; without it the
// operands pass unchanged and err_div_zero is tied low.
module div_share_arbiter
    import fia_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 16,
    parameter int DVD_W     = DVD_W_DEF,
    parameter int DVS_W     = DVS_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DVD_W-1:0]      req_dividend,
    input  logic [NUM_REQ*DVS_W-1:0]      req_divisor,
    output logic                          div_valid,
    output logic [DVD_W-1:0]              div_dividend,
    output logic [DVS_W-1:0]              div_divisor,
    input  logic                          div_dividend_tready,
    input  logic                          div_divisor_tready,
    input  logic [63:0]                   div_quotient,
    input  logic                          div_quotient_valid,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [31:0]                   rsp_degree,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err_orphan,
    output logic                          err_div_zero
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    arb_state_e           state_q;
    logic                 flush_pend_q;
    logic                 flush_done_q;

    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_s;
    logic [IDX_W-1:0]     gnt_idx_s;
    logic                 gnt_any_s;
    logic                 can_grant_s;
    logic                 hit_s;
    int                   scan_idx_s;

    logic [DVD_W-1:0]     sel_dvd_s;
    logic [DVS_W-1:0]     sel_dvs_s;
    logic                 div_valid_q, div_valid_d;
    logic [DVD_W-1:0]     div_dividend_q, div_dividend_d;
    logic [DVS_W-1:0]     div_divisor_q, div_divisor_d;

    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_degree_q, rsp_degree_d;
    logic                 err_orphan_q, err_orphan_d;
`ifdef DIV_ZERO_GUARD_EN
    logic                 err_div_zero_q, err_div_zero_d;
`endif

    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic [IDX_W-1:0]     pop_tag_s;
    logic [CNT_W-1:0]     fifo_count_s;
    logic [CNT_W-1:0]     fifo_count_nxt_s;

    div_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (IDX_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (gnt_any_s),
        .push_data (gnt_idx_s),
        .pop       (div_quotient_valid),
        .pop_data  (pop_tag_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .count_nxt (fifo_count_nxt_s)
    );

    // Round-robin scan starting at ptr; first valid requester wins the single grant.
    always_comb begin
        can_grant_s = (state_q != ST_DRAIN) && div_dividend_tready &&
                      div_divisor_tready && !fifo_full_s;
        gnt_idx_s   = '0;
        gnt_any_s   = 1'b0;
        hit_s       = 1'b0;
        scan_idx_s  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx_s = (int'(ptr_q) + k) % NUM_REQ;
            hit_s      = can_grant_s && !gnt_any_s && req_valid[scan_idx_s];
            gnt_idx_s  = hit_s ? scan_idx_s[IDX_W-1:0] : gnt_idx_s;
            gnt_any_s  = gnt_any_s | hit_s;
        end
        gnt_s = gnt_any_s ? (NUM_REQ'(1) << gnt_idx_s) : '0;
        if (gnt_any_s) begin
            if (gnt_idx_s == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_s + 1'b1;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Operand capture for the divider; operands hold while no grant is made.
    always_comb begin
        sel_dvd_s   = req_dividend[int'(gnt_idx_s) * DVD_W +: DVD_W];
        sel_dvs_s   = req_divisor[int'(gnt_idx_s) * DVS_W +: DVS_W];
        div_valid_d = gnt_any_s;
`ifdef DIV_ZERO_GUARD_EN
        err_div_zero_d = err_div_zero_q;
`endif
        if (gnt_any_s) begin
`ifdef DIV_ZERO_GUARD_EN
            if (sel_dvs_s == '0) begin
                div_dividend_d = '0;
                div_divisor_d  = DVS_W'(Q_ONE);
                err_div_zero_d = 1'b1;
            end else begin
                div_dividend_d = sel_dvd_s;
                div_divisor_d  = sel_dvs_s;
            end
`else
            div_dividend_d = sel_dvd_s;
            div_divisor_d  = sel_dvs_s;
`endif
        end else begin
            div_dividend_d = div_dividend_q;
            div_divisor_d  = div_divisor_q;
        end
    end

    // Quotient return: steer to the oldest tag, or flag an orphan if none is waiting.
    always_comb begin
        rsp_valid_d  = '0;
        rsp_degree_d = rsp_degree_q;
        err_orphan_d = err_orphan_q;
        if (div_quotient_valid) begin
            if (fifo_empty_s) begin
                err_orphan_d = 1'b1;
            end else begin
                rsp_valid_d  = NUM_REQ'(1) << pop_tag_s;
                rsp_degree_d = q12_degree(div_quotient);
            end
        end else begin
            rsp_valid_d = '0;
        end
    end

    // Datapath and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q          <= '0;
            div_valid_q    <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            rsp_valid_q    <= '0;
            rsp_degree_q   <= '0;
            err_orphan_q   <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            div_valid_q    <= div_valid_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_degree_q   <= rsp_degree_d;
            err_orphan_q   <= err_orphan_d;
        end
    end

`ifdef DIV_ZERO_GUARD_EN
    // Sticky divide-by-zero flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_div_zero_q <= 1'b0;
        end else begin
            err_div_zero_q <= err_div_zero_d;
        end
    end
    assign err_div_zero = err_div_zero_q;
`else
    assign err_div_zero = 1'b0;
`endif

    // Sequencer: tracks activity, holds a flush until draining starts, pulses when drained.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            flush_pend_q <= (state_q == ST_DRAIN) ? 1'b0 : (flush_pend_q | flush_req);
            case (state_q)
                ST_IDLE: begin
                    if (flush_req || flush_pend_q) begin
                        state_q <= ST_DRAIN;
                    end else if (|req_valid) begin
                        state_q <= ST_ACTIVE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (flush_req || flush_pend_q) begin
                        state_q <= ST_DRAIN;
                    end else if (!(|req_valid) && (fifo_count_s == '0)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_DRAIN: begin
                    // Leave as the last tag pops so flush_done lines up with the final response.
                    if (fifo_count_nxt_s == '0) begin
                        state_q      <= ST_IDLE;
                        flush_done_q <= 1'b1;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = gnt_s;
    assign div_valid    = div_valid_q;
    assign div_dividend = div_dividend_q;
    assign div_divisor  = div_divisor_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_degree   = rsp_degree_q;
    assign flush_done   = flush_done_q;
    assign outstanding  = fifo_count_s;
    assign err_orphan   = err_orphan_q;

endmodule
